// File: rtl/dtw_pkg.sv
// Shared constants and types for the DTW result path: record layout, FIFO timing
// and the result streamer FSM encoding.
package dtw_pkg;

    // Word positions inside a 3-word result record
    localparam int unsigned REC_QID   = 0;
    localparam int unsigned REC_POS   = 1;
    localparam int unsigned REC_MIN   = 2;
    localparam int unsigned REC_WORDS = 3;

    // Standard (non-FWFT) FIFO: read data appears this many cycles after rden
    localparam int unsigned FIFO_RD_LATENCY = 1;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StEval,
        StSend,
        StDrop
    } state_e;

    localparam logic [1:0] LAST_IDX = 2'(REC_WORDS - 1);

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/dtw_result_streamer_if.sv
// Result FIFO read port plus AXI4-Stream master channel of the DTW result streamer.
// The master modport is the streamer side; slave is the FIFO/DMA side.
interface dtw_result_streamer_if #(
    parameter int unsigned axi_dwidth = 32
) ();

    logic                  fifo_empty;
    logic                  fifo_rden;
    logic [axi_dwidth-1:0] fifo_dout;

    logic [axi_dwidth-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  m_axis_tready,
        output fifo_rden,
        output m_axis_tdata,
        output m_axis_tvalid,
        output m_axis_tlast
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output m_axis_tready,
        input  fifo_rden,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        input  m_axis_tlast
    );

endinterface

// File: rtl/dtw_result_streamer.sv
// Drains 3-word DTW result records from the sink FIFO, optionally drops them by a
// minval threshold and emits the survivors as 3-beat AXI4-Stream packets.
module dtw_result_streamer
    import dtw_pkg::*;
#(
    parameter int unsigned dtw_dwidth = 16,
    parameter int unsigned axi_dwidth = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  filter_en,
    input  logic [dtw_dwidth-1:0] thresh,
    dtw_result_streamer_if.master bus,
    output logic                  busy,
    output logic [31:0]           rec_count,
    output logic [31:0]           drop_count
);

    state_e                state_q, state_d;
    logic [1:0]            issued_q, issued_d;
    logic [1:0]            captured_q, captured_d;
    logic                  rd_vld_q;
    logic [axi_dwidth-1:0] rec_q [REC_WORDS];
    logic [1:0]            beat_q, beat_d;
    logic [axi_dwidth-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [31:0]           rec_cnt_q, rec_cnt_d;
    logic [31:0]           drop_cnt_q, drop_cnt_d;

    logic                  rden;
    logic                  capture;
    logic                  drop;
    logic                  next_ready;
    logic [1:0]            beat_nxt;

    assign capture    = (state_q == StRead) && rd_vld_q;
    assign drop       = filter_en && (rec_q[REC_MIN][dtw_dwidth-1:0] > thresh);
    assign next_ready = enable && !bus.fifo_empty;
    assign beat_nxt   = next_idx(beat_q);

    always_comb begin
        state_d    = state_q;
        issued_d   = issued_q;
        captured_d = captured_q;
        beat_d     = beat_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        rec_cnt_d  = rec_cnt_q;
        drop_cnt_d = drop_cnt_q;
        rden       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (next_ready) begin
                    state_d = StRead;
                end
            end

            StRead: begin
                rden = !bus.fifo_empty && (issued_q < 2'(REC_WORDS));
                if (rden) begin
                    issued_d = next_idx(issued_q);
                end
                if (rd_vld_q) begin
                    captured_d = next_idx(captured_q);
                    // Last word lands this cycle; counters are rearmed for the next record
                    if (captured_q == LAST_IDX) begin
                        state_d    = StEval;
                        issued_d   = 2'd0;
                        captured_d = 2'd0;
                    end
                end
            end

            StEval: begin
                if (drop) begin
                    state_d = StDrop;
                end else begin
                    state_d  = StSend;
                    beat_d   = 2'd0;
                    tdata_d  = rec_q[REC_QID];
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                end
            end

            StDrop: begin
                drop_cnt_d = drop_cnt_q + 32'd1;
                state_d    = StIdle;
            end

            StSend: begin
                if (tvalid_q && bus.m_axis_tready) begin
                    if (beat_q == LAST_IDX) begin
                        tvalid_d  = 1'b0;
                        tlast_d   = 1'b0;
                        beat_d    = 2'd0;
                        rec_cnt_d = rec_cnt_q + 32'd1;
                        // Fold the idle decision in here to hold one record per 8 cycles
                        state_d   = next_ready ? StRead : StIdle;
                    end else begin
                        beat_d  = beat_nxt;
                        tdata_d = rec_q[beat_nxt];
                        tlast_d = (beat_nxt == LAST_IDX);
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            issued_q   <= 2'd0;
            captured_q <= 2'd0;
            rd_vld_q   <= 1'b0;
            beat_q     <= 2'd0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            rec_cnt_q  <= 32'd0;
            drop_cnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            captured_q <= captured_d;
            rd_vld_q   <= rden;
            beat_q     <= beat_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            rec_cnt_q  <= rec_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(REC_WORDS); i++) begin
                rec_q[i] <= '0;
            end
        end else if (capture) begin
            rec_q[captured_q] <= bus.fifo_dout;
        end
    end

    assign bus.fifo_rden     = rden;
    assign bus.m_axis_tdata  = tdata_q;
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axis_tlast  = tlast_q;

    assign busy       = (state_q != StIdle);
    assign rec_count  = rec_cnt_q;
    assign drop_count = drop_cnt_q;

    // A stalled beat must be presented unchanged until accepted
    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.m_axis_tvalid && !bus.m_axis_tready) |=>
        (bus.m_axis_tvalid && $stable(bus.m_axis_tdata) && $stable(bus.m_axis_tlast)));

    a_rden_legal: assert property (@(posedge clk) disable iff (rst)
        bus.fifo_rden |-> (!bus.fifo_empty && (state_q == StRead)));

    a_no_valid_outside_send: assert property (@(posedge clk) disable iff (rst)
        bus.m_axis_tvalid |-> (state_q == StSend));

endmodule

// File: tb/tb_dtw_result_streamer.sv
// Directed self-checking bench for dtw_result_streamer with a behavioural result FIFO
// and an AXIS beat monitor.
module tb_dtw_result_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        filter_en;
    logic [15:0] thresh;
    logic        busy;
    logic [31:0] rec_count;
    logic [31:0] drop_count;

    dtw_result_streamer_if #(.axi_dwidth(32)) bus ();

    dtw_result_streamer #(
        .dtw_dwidth(16),
        .axi_dwidth(32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .filter_en (filter_en),
        .thresh    (thresh),
        .bus       (bus),
        .busy      (busy),
        .rec_count (rec_count),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Standard FIFO model: dout valid the cycle after rden
    logic [31:0] mem [256];
    logic [7:0]  wr_ptr = 8'd0;
    logic [7:0]  rd_ptr = 8'd0;

    assign bus.fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (bus.fifo_rden) begin
            bus.fifo_dout <= mem[rd_ptr];
            rd_ptr        <= rd_ptr + 8'd1;
        end
    end

    int          cyc = 0;
    int          nbeats = 0;
    logic [32:0] beats [64];
    int          bcyc [64];
    int          rden_cnt = 0;
    int          empty_viol = 0;
    int          stall_viol = 0;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_beat = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.fifo_rden) begin
            rden_cnt++;
            if (bus.fifo_empty) empty_viol++;
        end
        if (!rst) begin
            if (prev_stall && !(bus.m_axis_tvalid &&
                                {bus.m_axis_tlast, bus.m_axis_tdata} == prev_beat)) begin
                stall_viol++;
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready && nbeats < 64) begin
                beats[nbeats] = {bus.m_axis_tlast, bus.m_axis_tdata};
                bcyc[nbeats]  = cyc;
                nbeats++;
            end
        end
        prev_stall = !rst && bus.m_axis_tvalid && !bus.m_axis_tready;
        prev_beat  = {bus.m_axis_tlast, bus.m_axis_tdata};
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] bt(input logic last, input logic [31:0] d);
        return {31'd0, last, d};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr      = wr_ptr + 8'd1;
    endtask

    task automatic push_rec(input logic [31:0] q, input logic [31:0] p, input logic [31:0] m);
        push(q);
        push(p);
        push(m);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_beats(input int target, input int budget, input string tag);
        int k = 0;
        while (nbeats < target && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, 64'(nbeats >= target), 64'd1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while (busy && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int r;
        int k;

        rst = 1'b1;
        enable = 1'b0;
        filter_en = 1'b0;
        thresh = 16'd0;
        bus.m_axis_tready = 1'b0;
        tick(3);

        check("rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        check("rst_tlast", 64'(bus.m_axis_tlast), 64'd0);
        check("rst_tdata", 64'(bus.m_axis_tdata), 64'd0);
        check("rst_rden", 64'(bus.fifo_rden), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rec_count", 64'(rec_count), 64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);

        // 1: basic record
        rst = 1'b0;
        enable = 1'b1;
        bus.m_axis_tready = 1'b1;
        b = nbeats;
        r = rden_cnt;
        push_rec(32'd7, 32'd1234, 32'd40);
        wait_beats(b + 3, 40, "t1_beats_timeout");
        wait_idle(20, "t1_idle");
        check("t1_beat0", 64'(beats[b]), bt(1'b0, 32'd7));
        check("t1_beat1", 64'(beats[b+1]), bt(1'b0, 32'd1234));
        check("t1_beat2", 64'(beats[b+2]), bt(1'b1, 32'd40));
        check("t1_rec_count", 64'(rec_count), 64'd1);
        check("t1_rden_pulses", 64'(rden_cnt - r), 64'd3);
        check("t1_drop_count", 64'(drop_count), 64'd0);

        // 2: filter, minval 40 kept, 60 dropped, 50 == thresh kept
        do_reset();
        filter_en = 1'b1;
        thresh = 16'd50;
        b = nbeats;
        push_rec(32'd1, 32'd100, 32'd40);
        push_rec(32'd2, 32'd200, 32'd60);
        push_rec(32'd3, 32'd300, 32'd50);
        wait_beats(b + 6, 80, "t2_beats_timeout");
        wait_idle(20, "t2_idle");
        tick(4);
        check("t2_nbeats", 64'(nbeats - b), 64'd6);
        check("t2_rec0_qid", 64'(beats[b]), bt(1'b0, 32'd1));
        check("t2_rec0_min", 64'(beats[b+2]), bt(1'b1, 32'd40));
        check("t2_rec1_qid", 64'(beats[b+3]), bt(1'b0, 32'd3));
        check("t2_rec1_min", 64'(beats[b+5]), bt(1'b1, 32'd50));
        check("t2_rec_count", 64'(rec_count), 64'd2);
        check("t2_drop_count", 64'(drop_count), 64'd1);
        filter_en = 1'b0;

        // 3: backpressure with a 5-cycle hold mid-packet
        do_reset();
        bus.m_axis_tready = 1'b0;
        b = nbeats;
        push_rec(32'd11, 32'd22, 32'd33);
        for (int c = 0; c < 30; c++) begin
            bus.m_axis_tready = (c >= 7 && c < 12) ? 1'b0 : ((c % 2) == 0);
            tick(1);
        end
        bus.m_axis_tready = 1'b1;
        wait_beats(b + 3, 20, "t3_beats_timeout");
        wait_idle(20, "t3_idle");
        check("t3_nbeats", 64'(nbeats - b), 64'd3);
        check("t3_beat0", 64'(beats[b]), bt(1'b0, 32'd11));
        check("t3_beat1", 64'(beats[b+1]), bt(1'b0, 32'd22));
        check("t3_beat2", 64'(beats[b+2]), bt(1'b1, 32'd33));
        check("t3_stall_stable", 64'(stall_viol), 64'd0);
        check("t3_rec_count", 64'(rec_count), 64'd1);

        // 4: FIFO starved after w1
        do_reset();
        b = nbeats;
        r = rden_cnt;
        push(32'd5);
        push(32'd77);
        tick(15);
        check("t4_busy_held", 64'(busy), 64'd1);
        check("t4_rden_starved", 64'(rden_cnt - r), 64'd2);
        check("t4_no_beats", 64'(nbeats - b), 64'd0);
        check("t4_no_rden_empty", 64'(empty_viol), 64'd0);
        push(32'd123);
        wait_beats(b + 3, 40, "t4_beats_timeout");
        wait_idle(20, "t4_idle");
        check("t4_beat0", 64'(beats[b]), bt(1'b0, 32'd5));
        check("t4_beat1", 64'(beats[b+1]), bt(1'b0, 32'd77));
        check("t4_beat2", 64'(beats[b+2]), bt(1'b1, 32'd123));
        check("t4_rden_total", 64'(rden_cnt - r), 64'd3);
        check("t4_rec_count", 64'(rec_count), 64'd1);

        // 5: reset while beat 1 is presented
        bus.m_axis_tready = 1'b0;
        push_rec(32'd9, 32'd99, 32'd999);
        k = 0;
        while (!bus.m_axis_tvalid && k < 30) begin
            tick(1);
            k++;
        end
        check("t5_beat0_valid", 64'(bus.m_axis_tvalid), 64'd1);
        check("t5_beat0_data", 64'(bus.m_axis_tdata), 64'd9);
        bus.m_axis_tready = 1'b1;
        tick(1);
        check("t5_beat1_data", 64'(bus.m_axis_tdata), 64'd99);
        check("t5_beat1_tlast", 64'(bus.m_axis_tlast), 64'd0);
        check("t5_pre_rst_count", 64'(rec_count), 64'd1);
        bus.m_axis_tready = 1'b0;
        rst = 1'b1;
        tick(1);
        check("t5_rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_rec_count", 64'(rec_count), 64'd0);
        rst = 1'b0;
        bus.m_axis_tready = 1'b1;
        b = nbeats;
        push_rec(32'd3, 32'd33, 32'd333);
        wait_beats(b + 3, 40, "t5_beats_timeout");
        wait_idle(20, "t5_idle");
        check("t5_beat0", 64'(beats[b]), bt(1'b0, 32'd3));
        check("t5_beat2", 64'(beats[b+2]), bt(1'b1, 32'd333));
        check("t5_rec_count", 64'(rec_count), 64'd1);

        // 6: back-to-back, enable dropped after record 2's first read
        do_reset();
        b = nbeats;
        r = rden_cnt;
        for (int i = 0; i < 4; i++) begin
            push_rec(32'(100 + i), 32'(200 + i), 32'(300 + i));
        end
        k = 0;
        while ((rden_cnt - r) < 4 && k < 40) begin
            tick(1);
            k++;
        end
        enable = 1'b0;
        wait_beats(b + 6, 60, "t6_beats_timeout");
        wait_idle(30, "t6_idle");
        tick(10);
        check("t6_nbeats", 64'(nbeats - b), 64'd6);
        check("t6_rec1_qid", 64'(beats[b+3]), bt(1'b0, 32'd101));
        check("t6_rec1_min", 64'(beats[b+5]), bt(1'b1, 32'd301));
        check("t6_rec_count", 64'(rec_count), 64'd2);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_fifo_left", 64'(8'(wr_ptr - rd_ptr)), 64'd6);
        check("t6_rden_total", 64'(rden_cnt - r), 64'd6);
        check("t6_rate", 64'((bcyc[b+5] - bcyc[b+2]) <= 8), 64'd1);
        check("t6_no_rden_empty", 64'(empty_viol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
